// File: rtl/msx_reload_sequencer_pkg.sv
// Shared types and helpers for the MSX reload sequencer.
// Holds the sequencer state encoding and the counter sizing rule.
package msx_reload_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SAVE,
        CLEAR,
        HOLD,
        LATCH
    } reload_state_t;

    // A counter loaded with depth-1 needs $clog2(depth) bits, but never fewer than one.
    function automatic int cnt_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/msx_reload_sequencer_if.sv
// Bundles the configuration, SRAM-save and cartridge-clear signals of the reload sequencer.
// The master side is the sequencer itself; the slave side is the surrounding system.
interface msx_reload_sequencer_if #(
    parameter int CFG_W  = 19,
    parameter int ADDR_W = 14
) ();

    logic [CFG_W-1:0]  cfg_word;
    logic              ext_reset_req;
    logic              sram_dirty;
    logic              save_ack;
    logic              clr_ready;
    logic [CFG_W-1:0]  cfg_active;
    logic              cfg_latch;
    logic              msx_reset;
    logic              save_req;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              save_err;
    logic              busy;

    modport master (
        input  cfg_word, ext_reset_req, sram_dirty, save_ack, clr_ready,
        output cfg_active, cfg_latch, msx_reset, save_req, clr_we, clr_addr, save_err, busy
    );

    modport slave (
        output cfg_word, ext_reset_req, sram_dirty, save_ack, clr_ready,
        input  cfg_active, cfg_latch, msx_reset, save_req, clr_we, clr_addr, save_err, busy
    );

endinterface

// File: rtl/msx_reload_sequencer.sv
// Reload sequencer: debounces configuration edits, optionally saves SRAM, clears cartridge RAM,
// holds the core in reset and finally latches the new configuration as the active one.
module msx_reload_sequencer
    import msx_reload_sequencer_pkg::*;
#(
    parameter int CFG_W         = 19,
    parameter int SETTLE_CYCLES = 1024,
    parameter int SAVE_TIMEOUT  = 65535,
    parameter int CLEAR_DEPTH   = 16384,
    parameter int ADDR_W        = 14,
    parameter int RESET_HOLD    = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    msx_reload_sequencer_if.master bus
);

    localparam int CNT_W = cnt_width(max3(SETTLE_CYCLES, SAVE_TIMEOUT, RESET_HOLD));

    localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  SAVE_LOAD   = CNT_W'(SAVE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  HOLD_LOAD   = CNT_W'(RESET_HOLD - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST   = ADDR_W'(CLEAR_DEPTH - 1);

    reload_state_t     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CFG_W-1:0]  sample_q, sample_d;
    logic [CFG_W-1:0]  active_q, active_d;
    logic              live_q, live_d;
    logic              err_q, err_d;

    logic              msx_reset_q, msx_reset_d;
    logic              busy_q, busy_d;
    logic              save_req_q, save_req_d;
    logic              clr_we_q, clr_we_d;
    logic              latch_q, latch_d;

    // live_q selects what LATCH captures: the settled sample, or the live word after a plain reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= HOLD;
            cnt_q       <= HOLD_LOAD;
            addr_q      <= '0;
            sample_q    <= '0;
            active_q    <= '0;
            live_q      <= 1'b1;
            err_q       <= 1'b0;
            msx_reset_q <= 1'b1;
            busy_q      <= 1'b1;
            save_req_q  <= 1'b0;
            clr_we_q    <= 1'b0;
            latch_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            sample_q    <= sample_d;
            active_q    <= active_d;
            live_q      <= live_d;
            err_q       <= err_d;
            msx_reset_q <= msx_reset_d;
            busy_q      <= busy_d;
            save_req_q  <= save_req_d;
            clr_we_q    <= clr_we_d;
            latch_q     <= latch_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        sample_d = sample_q;
        active_d = active_q;
        live_d   = live_q;
        err_d    = err_q;

        unique case (state_q)
            IDLE: begin
                if (bus.cfg_word != active_q) begin
                    state_d  = SETTLE;
                    cnt_d    = SETTLE_LOAD;
                    sample_d = bus.cfg_word;
                    live_d   = 1'b0;
                end else if (bus.ext_reset_req) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LOAD;
                    live_d  = 1'b1;
                end
            end

            SETTLE: begin
                if (bus.cfg_word != sample_q) begin
                    cnt_d    = SETTLE_LOAD;
                    sample_d = bus.cfg_word;
                end else if (cnt_q == '0) begin
                    // An edit that was reverted before settling only pulses the core reset.
                    if (sample_q == active_q) begin
                        state_d = HOLD;
                        cnt_d   = HOLD_LOAD;
                    end else if (bus.sram_dirty) begin
                        state_d = SAVE;
                        cnt_d   = SAVE_LOAD;
                    end else begin
                        state_d = CLEAR;
                        addr_d  = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            SAVE: begin
                if (bus.save_ack) begin
                    state_d = CLEAR;
                    addr_d  = '0;
                end else if (cnt_q == '0) begin
                    state_d = CLEAR;
                    addr_d  = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            CLEAR: begin
                if (clr_we_q && bus.clr_ready) begin
                    if (addr_q == ADDR_LAST) begin
                        state_d = HOLD;
                        cnt_d   = HOLD_LOAD;
                        addr_d  = '0;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end

            HOLD: begin
                if (cnt_q == '0) begin
                    state_d  = LATCH;
                    active_d = live_q ? bus.cfg_word : sample_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            LATCH: begin
                state_d = IDLE;
            end

            default: begin
                state_d = HOLD;
                cnt_d   = HOLD_LOAD;
                live_d  = 1'b1;
            end
        endcase
    end

    // Outputs are registered from the next state so every strobe lines up with its state edge.
    always_comb begin
        msx_reset_d = (state_d != IDLE);
        busy_d      = (state_d != IDLE);
        save_req_d  = (state_d == SAVE);
        clr_we_d    = (state_d == CLEAR);
        latch_d     = (state_d == LATCH);
    end

    assign bus.cfg_active = active_q;
    assign bus.cfg_latch  = latch_q;
    assign bus.msx_reset  = msx_reset_q;
    assign bus.save_req   = save_req_q;
    assign bus.clr_we     = clr_we_q;
    assign bus.clr_addr   = addr_q;
    assign bus.save_err   = err_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_msx_reload_sequencer.sv
// Scoreboard bench for the reload sequencer, run with shrunken parameters so each sequence is short.
// Expected latches and clear addresses are queued when stimulus is driven and popped by a monitor.
module tb_msx_reload_sequencer;

    localparam int CFG_W   = 19;
    localparam int SETTLE  = 16;
    localparam int SAVE_TO = 40;
    localparam int DEPTH   = 32;
    localparam int ADDR_W  = 5;
    localparam int HOLD    = 8;
    localparam int MIN_SEQ = SETTLE + DEPTH + HOLD + 1;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    msx_reload_sequencer_if #(.CFG_W(CFG_W), .ADDR_W(ADDR_W)) bus ();

    msx_reload_sequencer #(
        .CFG_W(CFG_W), .SETTLE_CYCLES(SETTLE), .SAVE_TIMEOUT(SAVE_TO),
        .CLEAR_DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_HOLD(HOLD)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    int totalChecks = 0;
    int badChecks   = 0;
    int resetCycles = 0;
    int saveCycles  = 0;
    int clrWrites   = 0;
    bit stalledValid = 1'b0;
    logic [31:0] stalledAddr = '0;
    int unsigned cfgQ[$];
    int unsigned addrQ[$];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got 0x%0h want 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic resetCounters();
        resetCycles = 0;
        saveCycles  = 0;
        clrWrites   = 0;
    endtask

    task automatic applyStimulus(input int unsigned cfg, input bit expectLatch, input bit expectClear);
        if (expectLatch) cfgQ.push_back(cfg);
        if (expectClear) for (int i = 0; i < DEPTH; i++) addrQ.push_back(i);
        bus.cfg_word = CFG_W'(cfg);
    endtask

    task automatic waitIdle(input string tag, input bit toggleReady);
        bit done = 1'b0;
        int n = 0;
        while (!done && n < 400) begin
            @(posedge clk);
            #1;
            if (toggleReady) bus.clr_ready = ~bus.clr_ready;
            @(negedge clk);
            done = !bus.busy;
            n++;
        end
        checkOutput({tag, "_reached_idle"}, 32'(done), 32'd1);
        @(posedge clk);
        #1;
        bus.clr_ready = 1'b1;
    endtask

    task automatic checkDrained(input string tag);
        checkOutput({tag, "_cfg_pending"}, cfgQ.size(), 32'd0);
        checkOutput({tag, "_addr_pending"}, addrQ.size(), 32'd0);
    endtask

    task automatic runSave(input int k, input int unsigned cfg);
        bit seen = 1'b0;
        resetCounters();
        bus.sram_dirty = 1'b1;
        applyStimulus(cfg, 1'b1, 1'b1);
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = bus.save_req;
        end
        checkOutput("save_req_seen", 32'(seen), 32'd1);
        repeat (k - 1) begin
            @(posedge clk);
            #1;
        end
        bus.save_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.save_ack   = 1'b0;
        bus.sram_dirty = 1'b0;
        waitIdle("save_ack", 1'b0);
        checkOutput("save_req_len", saveCycles, k);
        checkOutput("save_err_after_ack", 32'(bus.save_err), 32'd0);
        checkOutput("save_clear_writes", clrWrites, DEPTH);
        checkDrained("save_ack");
    endtask

    // Monitor: per-cycle counters, stall stability, and scoreboard pops for writes and latches.
    always @(negedge clk) begin
        if (bus.msx_reset === 1'b1) resetCycles++;
        if (bus.save_req === 1'b1) saveCycles++;
        if (bus.clr_we === 1'b1 && stalledValid)
            checkOutput("addr_stall_hold", 32'(bus.clr_addr), stalledAddr);
        stalledValid = (bus.clr_we === 1'b1) && (bus.clr_ready === 1'b0);
        stalledAddr  = 32'(bus.clr_addr);
        if (bus.clr_we === 1'b1 && bus.clr_ready === 1'b1) begin
            clrWrites++;
            if (addrQ.size() == 0) checkOutput("unexpected_write", 32'(bus.clr_addr) | 32'h8000_0000, 32'd0);
            else checkOutput("clr_addr", 32'(bus.clr_addr), addrQ.pop_front());
        end
        if (bus.cfg_latch === 1'b1) begin
            if (cfgQ.size() == 0) checkOutput("unexpected_latch", 32'(bus.cfg_active) | 32'h8000_0000, 32'd0);
            else checkOutput("cfg_active_at_latch", 32'(bus.cfg_active), cfgQ.pop_front());
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no finish want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n           = 1'b1;
        bus.cfg_word      = CFG_W'(32'h1234);
        bus.ext_reset_req = 1'b0;
        bus.sram_dirty    = 1'b0;
        bus.save_ack      = 1'b0;
        bus.clr_ready     = 1'b1;
        #2 reset_n = 1'b0;
        stepCycles(3);

        checkOutput("rst_msx_reset", 32'(bus.msx_reset), 32'd1);
        checkOutput("rst_cfg_active", 32'(bus.cfg_active), 32'd0);
        checkOutput("rst_save_err", 32'(bus.save_err), 32'd0);
        checkOutput("rst_clr_we", 32'(bus.clr_we), 32'd0);
        checkOutput("rst_save_req", 32'(bus.save_req), 32'd0);
        checkOutput("rst_cfg_latch", 32'(bus.cfg_latch), 32'd0);
        checkOutput("rst_clr_addr", 32'(bus.clr_addr), 32'd0);

        cfgQ.push_back(32'h1234);
        resetCounters();
        reset_n = 1'b1;
        waitIdle("powerup", 1'b0);
        checkOutput("powerup_reset_len", resetCycles, HOLD + 1);
        checkOutput("powerup_active", 32'(bus.cfg_active), 32'h1234);
        checkOutput("powerup_writes", clrWrites, 0);
        checkDrained("powerup");

        // Debounce: three short-lived edits restart SETTLE, only the last word is applied.
        resetCounters();
        applyStimulus(32'h0001, 1'b0, 1'b0);
        checkOutput("detect_before_edge", 32'(bus.msx_reset), 32'd0);
        stepCycles(1);
        checkOutput("detect_latency", 32'(bus.msx_reset), 32'd1);
        stepCycles(4);
        applyStimulus(32'h0002, 1'b0, 1'b0);
        stepCycles(5);
        applyStimulus(32'h0003, 1'b0, 1'b0);
        stepCycles(5);
        applyStimulus(32'h0055, 1'b1, 1'b1);
        waitIdle("debounce", 1'b0);
        checkOutput("debounce_reset_len", resetCycles, 15 + MIN_SEQ);
        checkOutput("debounce_active", 32'(bus.cfg_active), 32'h0055);
        checkOutput("debounce_writes", clrWrites, DEPTH);
        checkDrained("debounce");

        // Reverted edit with dirty SRAM: no save, no clear, cfg_active unchanged.
        resetCounters();
        bus.sram_dirty = 1'b1;
        applyStimulus(32'h0077, 1'b0, 1'b0);
        stepCycles(3);
        applyStimulus(32'h0055, 1'b1, 1'b0);
        waitIdle("revert", 1'b0);
        bus.sram_dirty = 1'b0;
        checkOutput("revert_reset_len", resetCycles, 3 + SETTLE + HOLD + 1);
        checkOutput("revert_save_cycles", saveCycles, 0);
        checkOutput("revert_writes", clrWrites, 0);
        checkOutput("revert_active", 32'(bus.cfg_active), 32'h0055);
        checkDrained("revert");

        runSave(10, 32'h00AA);
        runSave(SAVE_TO, 32'h00BB);

        // Save timeout: save_req held for the full timeout, error becomes sticky.
        resetCounters();
        bus.sram_dirty = 1'b1;
        applyStimulus(32'h1ABCD, 1'b1, 1'b1);
        waitIdle("timeout", 1'b0);
        bus.sram_dirty = 1'b0;
        checkOutput("timeout_save_len", saveCycles, SAVE_TO);
        checkOutput("timeout_save_err", 32'(bus.save_err), 32'd1);
        checkDrained("timeout");

        resetCounters();
        applyStimulus(32'h2468, 1'b1, 1'b1);
        waitIdle("backpressure", 1'b1);
        checkOutput("bp_writes", clrWrites, DEPTH);
        checkOutput("bp_active", 32'(bus.cfg_active), 32'h2468);
        checkDrained("backpressure");

        // A config change and a user reset in the same cycle take the full clear path.
        resetCounters();
        applyStimulus(32'h0066, 1'b1, 1'b1);
        bus.ext_reset_req = 1'b1;
        stepCycles(1);
        bus.ext_reset_req = 1'b0;
        waitIdle("cfg_and_ext", 1'b0);
        checkOutput("cfg_ext_reset_len", resetCycles, MIN_SEQ);
        checkOutput("cfg_ext_writes", clrWrites, DEPTH);
        checkDrained("cfg_and_ext");

        // User reset alone: hold and relatch only; a second request mid-HOLD is ignored.
        resetCounters();
        cfgQ.push_back(32'h0066);
        bus.ext_reset_req = 1'b1;
        stepCycles(1);
        bus.ext_reset_req = 1'b0;
        stepCycles(3);
        bus.ext_reset_req = 1'b1;
        stepCycles(1);
        bus.ext_reset_req = 1'b0;
        waitIdle("ext_only", 1'b0);
        checkOutput("ext_reset_len", resetCycles, HOLD + 1);
        checkOutput("ext_writes", clrWrites, 0);
        checkOutput("ext_save_cycles", saveCycles, 0);
        checkOutput("save_err_sticky", 32'(bus.save_err), 32'd1);
        checkDrained("ext_only");

        // Abort mid-clear with reset_n, then the power-up sequence latches the current word.
        applyStimulus(32'h3BEEF, 1'b1, 1'b1);
        stepCycles(SETTLE + 1 + 5);
        checkOutput("abort_in_clear", 32'(bus.clr_we), 32'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("abort_clr_we", 32'(bus.clr_we), 32'd0);
        checkOutput("abort_msx_reset", 32'(bus.msx_reset), 32'd1);
        checkOutput("abort_save_err", 32'(bus.save_err), 32'd0);
        addrQ.delete();
        cfgQ.delete();
        cfgQ.push_back(32'h3BEEF);
        stepCycles(2);
        resetCounters();
        reset_n = 1'b1;
        waitIdle("abort", 1'b0);
        checkOutput("abort_reset_len", resetCycles, HOLD + 1);
        checkOutput("abort_writes", clrWrites, 0);
        checkOutput("abort_active", 32'(bus.cfg_active), 32'h3BEEF);
        checkDrained("abort");

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
